sobel_stream: RTL and testbench

Streaming 3x3 Sobel edge detector for raster-order grayscale frames of parametrised size.
- Sits between the grayscale-conversion output FIFO and the output FIFO that feeds the BMP writer.
- Uses internal line buffers, so it builds a true 3x3 window from a one-pixel-per-word stream.
- Emits exactly one saturated |Gx|+|Gy| magnitude per input pixel, with border masking.

---
 rtl/sobel_stream.sv | 171 +++++++++++++++++
 tb/tb_sobel_stream.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sobel_stream.sv
`default_nettype none
// ============================================================================
// Module   : sobel_stream
// Brief    : Streaming 3x3 Sobel |Gx|+|Gy| detector with two line buffers and
//            a zero border. Define SOBEL_THRESHOLD_EN to binarise the output
//            against THRESHOLD.
// Revision : 1.0
// ============================================================================
module sobel_stream #(
    parameter int WIDTH      = 720,
    parameter int HEIGHT     = 540,
    parameter int DWIDTH_IN  = 8,
    parameter int DWIDTH_OUT = 8,
    parameter int THRESHOLD  = 128
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  fifo_in_rd_en,
    input  logic [DWIDTH_IN-1:0]  fifo_in_dout,
    input  logic                  fifo_in_empty,
    output logic                  fifo_out_wr_en,
    output logic [DWIDTH_OUT-1:0] fifo_out_din,
    input  logic                  fifo_out_full,
    output logic                  frame_done
);

    localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int GW = DWIDTH_IN + 3;
    localparam int SW = DWIDTH_IN + 4;
    localparam logic [CW-1:0]         COL_LAST   = CW'(WIDTH - 1);
    localparam logic [RW-1:0]         ROW_LAST   = RW'(HEIGHT - 1);
    localparam logic [DWIDTH_OUT-1:0] OUT_MAX    = '1;
    localparam logic [DWIDTH_OUT:0]   THRESH_LVL = (DWIDTH_OUT + 1)'(THRESHOLD);
`ifdef SOBEL_THRESHOLD_EN
    localparam bit THRESH_EN = 1'b1;
`else
    localparam bit THRESH_EN = 1'b0;
`endif

    logic [CW-1:0]         col_q, col_d;
    logic [RW-1:0]         row_q, row_d;
    logic                  out_valid_q, out_valid_d;
    logic [DWIDTH_OUT-1:0] out_data_q, out_data_d;
    logic [DWIDTH_IN-1:0]  win_q [3][3];
    logic [DWIDTH_IN-1:0]  win_d [3][3];
    logic [DWIDTH_IN-1:0]  lb0_q [WIDTH];
    logic [DWIDTH_IN-1:0]  lb1_q [WIDTH];

    logic                  accept;
    logic                  last_col;
    logic                  last_row;
    logic                  border;
    logic [DWIDTH_IN-1:0]  lb0_rd;
    logic [DWIDTH_IN-1:0]  lb1_rd;
    logic signed [GW-1:0]  gx;
    logic signed [GW-1:0]  gy;
    logic [GW-1:0]         abs_gx;
    logic [GW-1:0]         abs_gy;
    logic [SW-1:0]         mag;
    logic [DWIDTH_OUT-1:0] mag_sat;
    logic [DWIDTH_OUT-1:0] result;

    function automatic logic signed [GW-1:0] ext(input logic [DWIDTH_IN-1:0] v);
        return signed'({3'b000, v});
    endfunction

    // Reset gates both handshakes so no word is popped or pushed while clearing.
    assign accept         = !reset && !fifo_in_empty && (!out_valid_q || !fifo_out_full);
    assign fifo_in_rd_en  = accept;
    assign fifo_out_wr_en = !reset && out_valid_q && !fifo_out_full;
    assign fifo_out_din   = out_data_q;
    assign last_col       = (col_q == COL_LAST);
    assign last_row       = (row_q == ROW_LAST);
    assign frame_done     = accept && last_col && last_row;
    assign lb0_rd         = lb0_q[col_q];
    assign lb1_rd         = lb1_q[col_q];

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Shifted window: the gradient sees the column being accepted this cycle.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            win_d[r][0] = win_q[r][1];
            win_d[r][1] = win_q[r][2];
        end
        win_d[0][2] = lb1_rd;
        win_d[1][2] = lb0_rd;
        win_d[2][2] = fifo_in_dout;
    end

    always_comb begin
        gx = (ext(win_d[0][2]) + (ext(win_d[1][2]) <<< 1) + ext(win_d[2][2]))
           - (ext(win_d[0][0]) + (ext(win_d[1][0]) <<< 1) + ext(win_d[2][0]));
        gy = (ext(win_d[2][0]) + (ext(win_d[2][1]) <<< 1) + ext(win_d[2][2]))
           - (ext(win_d[0][0]) + (ext(win_d[0][1]) <<< 1) + ext(win_d[0][2]));
        abs_gx = gx[GW-1] ? $unsigned(-gx) : $unsigned(gx);
        abs_gy = gy[GW-1] ? $unsigned(-gy) : $unsigned(gy);
        mag    = {1'b0, abs_gx} + {1'b0, abs_gy};
    end

    generate
        if (DWIDTH_OUT < SW) begin : g_sat_clip
            assign mag_sat = (|mag[SW-1:DWIDTH_OUT]) ? OUT_MAX : mag[DWIDTH_OUT-1:0];
        end else if (DWIDTH_OUT == SW) begin : g_sat_exact
            assign mag_sat = mag;
        end else begin : g_sat_pad
            assign mag_sat = {{(DWIDTH_OUT - SW){1'b0}}, mag};
        end
    endgenerate

    // Border masking hides wrapped columns and line-buffer contents not yet written.
    always_comb begin
        if (THRESH_EN) begin
            result = ({1'b0, mag_sat} >= THRESH_LVL) ? OUT_MAX : '0;
        end else begin
            result = mag_sat;
        end
        border      = (col_q < CW'(2)) || (row_q < RW'(2));
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = border ? '0 : result;
        end else if (fifo_out_wr_en) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            col_q       <= '0;
            row_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            if (accept) begin
                win_q <= win_d;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            lb1_q[col_q] <= lb0_rd;
            lb0_q[col_q] <= fifo_in_dout;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sobel_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_sobel_stream
// Brief    : Self-checking bench for sobel_stream (8x6 frames) against a
//            frame-array Sobel reference model.
// Revision : 1.0
// ============================================================================
module tb_sobel_stream;

    localparam int W   = 8;
    localparam int H   = 6;
    localparam int N   = W * H;
    localparam int THR = 128;

    logic       clock;
    logic       reset;
    logic       fifo_in_rd_en;
    logic [7:0] fifo_in_dout;
    logic       fifo_in_empty;
    logic       fifo_out_wr_en;
    logic [7:0] fifo_out_din;
    logic       fifo_out_full;
    logic       frame_done;

    sobel_stream #(
        .WIDTH      (W),
        .HEIGHT     (H),
        .DWIDTH_IN  (8),
        .DWIDTH_OUT (8),
        .THRESHOLD  (THR)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .fifo_in_rd_en  (fifo_in_rd_en),
        .fifo_in_dout   (fifo_in_dout),
        .fifo_in_empty  (fifo_in_empty),
        .fifo_out_wr_en (fifo_out_wr_en),
        .fifo_out_din   (fifo_out_din),
        .fifo_out_full  (fifo_out_full),
        .frame_done     (frame_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks     = 0;
    int failures   = 0;
    int in_q[$];
    int exp_q[$];
    int img [H][W];
    int acc_k      = 0;
    int n_wr       = 0;
    int n_fd       = 0;
    int bubble_pct = 0;
    int full_pct   = 0;
    bit full_force = 1'b0;
    bit rst_req    = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Output for pixel (c,r) is the gradient centred one pixel up-left, zero on the border.
    function automatic int sobel_ref(input int c, input int r);
        int gx, gy, m;
        if (r < 2 || c < 2) return 0;
        gx = (img[r-2][c] + 2*img[r-1][c] + img[r][c])
           - (img[r-2][c-2] + 2*img[r-1][c-2] + img[r][c-2]);
        gy = (img[r][c-2] + 2*img[r][c-1] + img[r][c])
           - (img[r-2][c-2] + 2*img[r-2][c-1] + img[r-2][c]);
        m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        if (m > 255) m = 255;
`ifdef SOBEL_THRESHOLD_EN
        m = (m >= THR) ? 255 : 0;
`endif
        return m;
    endfunction

    // One cycle: drive at negedge, then predict and check what the next posedge does.
    task automatic tick();
        bit pend;
        int c, r, px;
        @(negedge clock);
        reset         = rst_req;
        fifo_in_empty = (in_q.size() == 0) || ($urandom_range(99) < bubble_pct);
        fifo_in_dout  = (in_q.size() != 0) ? 8'(in_q[0]) : 8'($urandom);
        fifo_out_full = full_force || ($urandom_range(99) < full_pct);
        #1;
        if (reset) begin
            chk("rst_rd_en", fifo_in_rd_en, 0);
            chk("rst_wr_en", fifo_out_wr_en, 0);
            exp_q.delete();
            acc_k = 0;
        end else begin
            pend = (exp_q.size() != 0);
            chk("rd_en", fifo_in_rd_en, !fifo_in_empty && (!pend || !fifo_out_full));
            chk("wr_en", fifo_out_wr_en, pend && !fifo_out_full);
            chk("frame_done", frame_done, fifo_in_rd_en && (acc_k == N - 1));
            if (fifo_out_wr_en) begin
                n_wr++;
                if (exp_q.size() == 0) chk("unexpected_wr", fifo_out_wr_en, 0);
                else                   chk("dout", fifo_out_din, exp_q.pop_front());
            end
            if (fifo_in_rd_en && in_q.size() != 0) begin
                c  = acc_k % W;
                r  = acc_k / W;
                px = in_q.pop_front();
                img[r][c] = px;
                exp_q.push_back(sobel_ref(c, r));
                acc_k = (acc_k + 1) % N;
            end
            if (frame_done) n_fd++;
        end
    endtask

    task automatic push_frame(input int kind, input int count);
        int c;
        for (int k = 0; k < count; k++) begin
            c = k % W;
            case (kind)
                0:       in_q.push_back(100);
                1:       in_q.push_back(c < 4 ? 0 : 200);
                2:       in_q.push_back(10 * c);
                default: in_q.push_back(int'($urandom_range(255)));
            endcase
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((in_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        chk("drain_timeout", (in_q.size() != 0 || exp_q.size() != 0), 0);
    endtask

    task automatic run_frames(input string tag, input int kind, input int frames);
        n_wr = 0;
        n_fd = 0;
        for (int f = 0; f < frames; f++) push_frame(kind, N);
        drain(2000 * frames);
        chk({tag, "_writes"}, n_wr, N * frames);
        chk({tag, "_frame_done"}, n_fd, frames);
    endtask

    initial begin
        reset         = 1'b1;
        fifo_in_empty = 1'b1;
        fifo_in_dout  = '0;
        fifo_out_full = 1'b0;
        repeat (3) tick();
        rst_req = 1'b0;
        tick();
        chk("reset_din", fifo_out_din, 0);
        chk("reset_wr_en", fifo_out_wr_en, 0);
        chk("reset_rd_en", fifo_in_rd_en, 0);
        chk("reset_frame_done", frame_done, 0);

        run_frames("flat", 0, 1);
        run_frames("step", 1, 1);
        run_frames("ramp", 2, 1);

        // Output backpressure held while a result is pending.
        n_wr = 0;
        n_fd = 0;
        push_frame(1, N);
        for (int n = 0; n < 100 && acc_k < 12; n++) tick();
        full_force = 1'b1;
        repeat (5) begin
            tick();
            chk("hold_rd_en", fifo_in_rd_en, 0);
            chk("hold_wr_en", fifo_out_wr_en, 0);
            chk("hold_din", fifo_out_din, exp_q.size() != 0 ? exp_q[0] : -1);
        end
        full_force = 1'b0;
        drain(2000);
        chk("hold_writes", n_wr, N);
        chk("hold_frame_done", n_fd, 1);

        // Reset mid-frame with the 20th result still pending.
        n_wr = 0;
        n_fd = 0;
        push_frame(2, 20);
        for (int n = 0; n < 200 && in_q.size() != 0; n++) tick();
        full_force = 1'b1;
        rst_req    = 1'b1;
        tick();
        rst_req    = 1'b0;
        full_force = 1'b0;
        repeat (4) tick();
        chk("partial_writes", n_wr, 19);
        run_frames("post_reset_ramp", 2, 1);

        // Random pixels with input bubbles and output stalls, frames back-to-back.
        bubble_pct = 30;
        full_pct   = 30;
        run_frames("random", 3, 2);
        run_frames("random_step", 1, 1);
        bubble_pct = 0;
        full_pct   = 0;
        run_frames("back_to_back", 3, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
